keypad_encoder: RTL and testbench
=================================

# keypad_encoder

Scans the calculator's 4x4 matrix keypad, debounces presses, and emits one 4-bit key code per physical press on `tecla` with a single-cycle `ready` strobe. It is the producing end of the key-code interface consumed by the calculator control FSM (digits 0–9, sum, subtract, store, load, enter, 15 = no-op). It drives keypad columns, reads rows, and rejects bounce and multi-key ghosting.

## Interface
- `SCAN_DIV`, default 16, clock cycles each column is driven (dwell). Minimum 4.
- `DEBOUNCE`, default 4, consecutive identical samples needed to accept a press or a release. Minimum 1.
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high.
- `row`  in  4  keypad rows, active-low (pulled up externally), asynchronous to `clk`.
- `col`  out  4  column drive, active-low, exactly one bit low at all times.
- `tecla`  out  4  key code of last accepted press; held until next accepted press.
- `ready`  out  1  one-cycle pulse: `tecla` is new this cycle.
- `key_held`  out  1  high from accepted press until accepted release.

## Operation
- Reset values: `col`=4'b1110 (column 0), `tecla`=4'h0, `ready`=0, `key_held`=0, state SCAN, dwell counter 0, debounce counter 0, synchronizer flops all-ones.
- `row` passes through a 2-flop synchronizer. All sampling uses the synchronized value `rs`.
- Dwell counter counts 0..SCAN_DIV-1 and wraps. The sample instant is count == SCAN_DIV-1.
- Key code = {row_index[1:0], col_index[1:0]}, where index = position of the low bit.
- States:
  - SCAN: at each sample instant:
    - If `rs` has exactly one low bit: capture code and pattern, set debounce count to 1, hold the column, go DEBOUNCE. With DEBOUNCE=1, go directly to accept.
    - Otherwise (all high, or 2+ low = ghost/invalid): advance to column (idx+1) mod 4, wrapping 3→0.
  - DEBOUNCE: column held; at each sample instant:
    - If `rs` equals the captured pattern, increment the count. Reaching DEBOUNCE means accept: load `tecla`, pulse `ready`, set `key_held`, go HELD.
    - Any mismatch (including bounce to all-high or a second row): go SCAN with no output. Advance to the next column.
  - HELD: column held; at each sample instant:
    - `rs` all-high increments the release count; anything else clears it.
    - Release count reaching DEBOUNCE: clear `key_held`, go SCAN, advance column.
    - No further `ready` while held; no auto-repeat.
- No backpressure: the consumer samples `tecla` in the cycle `ready` is high.
- A second key pressed while HELD is ignored. The first key's release completes only when all rows read high. The second key is then detected by a fresh scan.
- `reset` asserted at any point (mid-debounce, mid-hold) returns all registers to reset values immediately. No `ready` pulse may occur during or because of reset.

## Timing
- `ready` and `tecla` are registered. `ready` rises the cycle after the sample instant of the DEBOUNCE-th matching sample, and lasts exactly 1 cycle.
- `tecla` changes only in the cycle `ready` rises.
- Column switching happens in the cycle after a sample instant, so each new column gets SCAN_DIV cycles of settle plus sync before its first sample (hence the SCAN_DIV ≥ 4 minimum).
- Worst-case press-to-`ready` latency: (3 + DEBOUNCE)·SCAN_DIV + 3 cycles, for a stable press.
- Accepted release-to-`key_held` low: DEBOUNCE·SCAN_DIV + 3 cycles maximum.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE=3. Cycle 0 is the first edge after `reset` deasserts.
- Row 0 held low from before reset (key at row 0, column 0): samples at cycles 3, 7, 11 → `ready`=1 only in cycle 12, `tecla`=4'h0, `key_held`=1. Then row released → `key_held`=0 after 3 all-high samples. No second `ready`.
- Press at row 2, column 1 (code 4'h9) while scanning → exactly one `ready` with `tecla`=4'h9. `col` freezes at 4'b1101 while held. Scan resumes at column 2 after release.
- Bounce: row pattern toggles low/high on alternate samples for 20 cycles, then stays low → no `ready` during the bounce. One `ready` after 3 consecutive stable samples.
- Ghost: rows 0 and 3 both low on the same column → no `ready`, `col` keeps rotating 1110→1101→1011→0111→1110.
- Hold the code-14 key (row 3, column 2) for 200 cycles → exactly one `ready` (`tecla`=4'hE), no repeat. `tecla` is still 4'hE after release until the next press.
- Assert `reset` in cycle 9, mid-debounce (after 2 matching samples) → `col`=4'b1110, `ready`=0, `key_held`=0, `tecla`=0 immediately. No `ready` until 3 fresh samples after reset deasserts.

Source files
------------

// File: rtl/keypad_encoder_if.sv
// keypad_encoder_if: key-code bundle between the keypad scanner and the calculator control FSM
interface keypad_encoder_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] tecla;
  logic       ready;
  logic       key_held;
  modport master(input row, output col, tecla, ready, key_held);
  modport slave(output row, input col, tecla, ready, key_held);
endinterface

// File: rtl/keypad_encoder.sv
// keypad_encoder: scans a 4x4 keypad, debounces, rejects ghosting, emits one code per press
module keypad_encoder #(
  parameter int SCAN_DIV = 16,
  parameter int DEBOUNCE = 4
) (
  input logic              clk,
  input logic              reset,
  keypad_encoder_if.master kp
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] SLAST = CW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE - 1);
  typedef enum logic [1:0] {SCAN, DEB, HELD} state_t;
  state_t        state;
  logic [3:0]    r1, rs, pat, cap, n, code;
  logic [CW-1:0] cnt;
  logic [DW-1:0] dcnt;
  logic [1:0]    ci;
  logic          sample, one_low;
  assign n       = ~rs;
  assign one_low = n != 4'h0 && (n & (n - 4'h1)) == 4'h0;
  assign code    = {n[3] | n[2], n[3] | n[1], ci};
  assign sample  = cnt == SLAST;
  assign kp.col  = ~(4'b0001 << ci);
  // two-flop row synchronizer and per-column dwell counter
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r1  <= 4'hF;
      rs  <= 4'hF;
      cnt <= '0;
    end else begin
      r1  <= kp.row;
      rs  <= r1;
      cnt <= sample ? '0 : cnt + CW'(1);
    end
  // scan / debounce / hold machine; counts press matches in DEB and release samples in HELD
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state       <= SCAN;
      ci          <= '0;
      dcnt        <= '0;
      pat         <= 4'hF;
      cap         <= 4'h0;
      kp.tecla    <= 4'h0;
      kp.ready    <= 1'b0;
      kp.key_held <= 1'b0;
    end else begin
      kp.ready <= 1'b0;
      if (sample)
        case (state)
          SCAN:
            if (!one_low) ci <= ci + 2'd1;
            else if (DEBOUNCE == 1) begin
              kp.tecla    <= code;
              kp.ready    <= 1'b1;
              kp.key_held <= 1'b1;
              dcnt        <= '0;
              state       <= HELD;
            end else begin
              cap   <= code;
              pat   <= rs;
              dcnt  <= DW'(1);
              state <= DEB;
            end
          DEB:
            if (rs != pat) begin
              ci    <= ci + 2'd1;
              state <= SCAN;
            end else if (dcnt == DLAST) begin
              kp.tecla    <= cap;
              kp.ready    <= 1'b1;
              kp.key_held <= 1'b1;
              dcnt        <= '0;
              state       <= HELD;
            end else dcnt <= dcnt + DW'(1);
          HELD:
            if (rs != 4'hF) dcnt <= '0;
            else if (dcnt == DLAST) begin
              kp.key_held <= 1'b0;
              dcnt        <= '0;
              ci          <= ci + 2'd1;
              state       <= SCAN;
            end else dcnt <= dcnt + DW'(1);
          default: state <= SCAN;
        endcase
    end
endmodule

// File: tb/tb_keypad_encoder.sv
// tb_keypad_encoder: keypad matrix model plus press-level scoreboard for keypad_encoder
module tb_keypad_encoder;
  localparam int S   = 4;
  localparam int D   = 3;
  localparam int LAT = (3 + D) * S + 3;
  localparam int REL = D * S + 3;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] pressed = '0;
  logic [3:0] keyrow;
  int tests = 0;
  int fails = 0;
  int nready = 0;
  logic [3:0] obs[$];
  keypad_encoder_if kp();
  keypad_encoder #(.SCAN_DIV(S), .DEBOUNCE(D)) dut (.clk(clk), .reset(reset), .kp(kp));
  always #5 clk = ~clk;
  // a pressed key at (r,c) pulls row r low while column c is driven low
  always_comb begin
    keyrow = 4'hF;
    for (int k = 0; k < 16; k++) if (pressed[k] && !kp.col[k % 4]) keyrow[k / 4] = 1'b0;
  end
  assign kp.row = keyrow;
  // record every strobe the consumer would see
  always @(negedge clk) if (kp.ready) begin
    nready++;
    obs.push_back(kp.tecla);
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask
  task automatic wait_ready(input int maxc, output int got);
    got = -1;
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (kp.ready) begin
        got = i;
        break;
      end
    end
  endtask
  task automatic wait_release(input int maxc, output int got);
    got = -1;
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (!kp.key_held) begin
        got = i;
        break;
      end
    end
  endtask
  task automatic boot_count(output int first, output int cnt);
    first = -1;
    cnt = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (kp.ready) begin
        cnt++;
        if (first < 0) first = k;
      end
    end
  endtask
  typedef struct {
    int         key;
    logic [3:0] tecla;
    logic [3:0] col;
    logic [3:0] next_col;
  } vec_t;
  vec_t tbl[6];
  initial begin
    int got, first, cnt, n0, base, key, k2, trans;
    logic [3:0] prev;
    logic [3:0] exp_q[$];
    tbl[0] = '{9,  4'h9, 4'b1101, 4'b1011};
    tbl[1] = '{5,  4'h5, 4'b1101, 4'b1011};
    tbl[2] = '{15, 4'hF, 4'b0111, 4'b1110};
    tbl[3] = '{3,  4'h3, 4'b0111, 4'b1110};
    tbl[4] = '{12, 4'hC, 4'b1110, 4'b1101};
    tbl[5] = '{6,  4'h6, 4'b1011, 4'b0111};
    pressed = 16'h0001;
    tick(3);
    check("reset_col", kp.col, 4'b1110);
    check("reset_tecla", kp.tecla, 4'h0);
    check("reset_ready", kp.ready, 1'b0);
    check("reset_held", kp.key_held, 1'b0);
    reset = 1'b0;
    boot_count(first, cnt);
    check("boot_ready_cycle", first, 11);
    check("boot_ready_count", cnt, 1);
    check("boot_tecla", kp.tecla, 4'h0);
    check("boot_held", kp.key_held, 1'b1);
    pressed = '0;
    wait_release(REL + 1, got);
    check("boot_release", got >= 0, 1'b1);
    n0 = nready;
    tick(40);
    check("boot_no_repeat", nready - n0, 0);
    for (int i = 0; i < 6; i++) begin
      n0 = nready;
      pressed = 16'(1) << tbl[i].key;
      wait_ready(LAT + 2, got);
      check($sformatf("tbl%0d_ready", i), got >= 0, 1'b1);
      check($sformatf("tbl%0d_tecla", i), kp.tecla, tbl[i].tecla);
      check($sformatf("tbl%0d_held", i), kp.key_held, 1'b1);
      check($sformatf("tbl%0d_col", i), kp.col, tbl[i].col);
      tick(20);
      check($sformatf("tbl%0d_col_frozen", i), kp.col, tbl[i].col);
      check($sformatf("tbl%0d_one_ready", i), nready - n0, 1);
      pressed = '0;
      wait_release(REL + 1, got);
      check($sformatf("tbl%0d_release", i), got >= 0, 1'b1);
      check($sformatf("tbl%0d_next_col", i), kp.col, tbl[i].next_col);
      tick(5);
    end
    n0 = nready;
    pressed = 16'(1) << 14;
    wait_ready(LAT + 2, got);
    check("hold_ready", got >= 0, 1'b1);
    check("hold_tecla", kp.tecla, 4'hE);
    tick(200);
    check("hold_no_repeat", nready - n0, 1);
    pressed = '0;
    wait_release(REL + 1, got);
    check("hold_release", got >= 0, 1'b1);
    tick(30);
    check("hold_tecla_kept", kp.tecla, 4'hE);
    n0 = nready;
    for (int i = 0; i < 3; i++) begin
      pressed = 16'(1) << 9;
      tick(4);
      pressed = '0;
      tick(4);
    end
    check("bounce_no_ready", nready - n0, 0);
    pressed = 16'(1) << 9;
    wait_ready(LAT + 2, got);
    check("bounce_ready", got >= 0, 1'b1);
    check("bounce_tecla", kp.tecla, 4'h9);
    pressed = '0;
    wait_release(REL + 1, got);
    check("bounce_release", got >= 0, 1'b1);
    n0 = nready;
    pressed = 16'h1001;
    prev = kp.col;
    trans = 0;
    for (int i = 0; i < 40 && trans < 4; i++) begin
      tick();
      if (kp.col != prev) begin
        check("ghost_rotate", kp.col, {prev[2:0], prev[3]});
        prev = kp.col;
        trans++;
      end
    end
    check("ghost_transitions", trans, 4);
    check("ghost_no_ready", nready - n0, 0);
    pressed = '0;
    tick(5);
    pressed = 16'(1) << 6;
    wait_ready(LAT + 2, got);
    check("midhold_ready", got >= 0, 1'b1);
    tick(5);
    reset = 1'b1;
    #1;
    check("midhold_col", kp.col, 4'b1110);
    check("midhold_held", kp.key_held, 1'b0);
    check("midhold_tecla", kp.tecla, 4'h0);
    pressed = 16'(1) << 4;
    tick(3);
    reset = 1'b0;
    tick(9);
    n0 = nready;
    reset = 1'b1;
    #1;
    check("middeb_col", kp.col, 4'b1110);
    check("middeb_ready", kp.ready, 1'b0);
    check("middeb_held", kp.key_held, 1'b0);
    tick(2);
    check("middeb_no_ready_in_reset", nready - n0, 0);
    reset = 1'b0;
    boot_count(first, cnt);
    check("middeb_fresh_cycle", first, 11);
    check("middeb_fresh_count", cnt, 1);
    check("middeb_tecla", kp.tecla, 4'h4);
    pressed = '0;
    wait_release(REL + 1, got);
    check("middeb_release", got >= 0, 1'b1);
    tick(5);
    base = obs.size();
    for (int t = 0; t < 16; t++) begin
      key = int'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) begin
        k2 = ((key / 4 + int'($urandom_range(1, 3))) % 4) * 4 + key % 4;
        pressed = (16'(1) << key) | (16'(1) << k2);
        tick(LAT + 5);
        pressed = '0;
        tick(REL + 5);
      end else begin
        exp_q.push_back(4'(key));
        pressed = 16'(1) << key;
        wait_ready(LAT + 1, got);
        check("rand_latency", got >= 0, 1'b1);
        tick(int'($urandom_range(0, 40)));
        pressed = '0;
        wait_release(REL + 1, got);
        check("rand_release", got >= 0, 1'b1);
        tick(int'($urandom_range(0, 20)));
      end
    end
    check("rand_count", obs.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < obs.size(); i++)
      check($sformatf("rand_code%0d", i), obs[base + i], exp_q[i]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
